// File: rtl/sub_9bit_serial_if.sv
// Handshake/operand bundle for sub_9bit_serial: operand input side and result output side.
interface sub_9bit_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] a;
    logic [8:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] diff;
    logic       borrow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/sub_9bit_serial.sv
// Bit-serial 9-bit unsigned subtractor (a - b, 10-bit two's complement result), LSB first.
// Optional macro SUB_9BIT_SAT_EN: negative results are presented as zero, borrow still set.
module sub_9bit_serial (
    input  logic                     clk,
    input  logic                     rst_n,
    sub_9bit_serial_if.slave         bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       br_q, br_d;
    logic [8:0] a_q, a_d;
    logic [8:0] b_q, b_d;
    logic [8:0] acc_q, acc_d;
    logic [9:0] diff_q, diff_d;
    logic       borrow_q, borrow_d;

    logic       bit_d;
    logic       br_nx;

    // Operands shift right each RUN cycle, so bit i always sits at position 0.
    assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[8:1]};
                b_d   = {1'b0, b_q[8:1]};
                acc_d = {bit_d, acc_q[8:1]};
                br_d  = br_nx;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    state_d  = DONE;
                    diff_d   = {br_nx, bit_d, acc_q[8:1]};
                    borrow_d = br_nx;
`ifdef SUB_9BIT_SAT_EN
                    if (br_nx) begin
                        diff_d = '0;
                    end
`else
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;

endmodule
